// File: rtl/lcd_scanout_if.sv
// Video/framebuffer bundle for lcd_scanout: framebuffer read port, bank select, PPU frame pulse
// and the raster outputs. master = scanout side, slave = framebuffer RAM / video sink side.
interface lcd_scanout_if;
    logic [14:0] fb_a;
    logic [1:0]  fb_dout;
    logic        frame_done;
    logic        fb_bank;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [11:0] rgb;

    modport master (
        output fb_a, fb_bank, hsync, vsync, de, rgb,
        input  fb_dout, frame_done
    );

    modport slave (
        input  fb_a, fb_bank, hsync, vsync, de, rgb,
        output fb_dout, frame_done
    );
endinterface

// File: rtl/lcd_scanout.sv
// Raster timing generator and framebuffer reader for a 160x144 2-bit LCD image, scaled and centred.
// Define LCD_SCANOUT_DBUF_EN to swap framebuffer banks at vsync after each completed PPU frame.
module lcd_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SCALE    = 3,
    parameter int X_OFF    = 80,
    parameter int Y_OFF    = 24
) (
    input  logic          clk,
    input  logic          rst,
    lcd_scanout_if.master bus
);
    localparam int CW      = 12;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] WX_BEG = CW'(X_OFF);
    localparam logic [CW-1:0] WX_END = CW'(X_OFF + 160 * SCALE);
    localparam logic [CW-1:0] WY_BEG = CW'(Y_OFF);
    localparam logic [CW-1:0] WY_END = CW'(Y_OFF + 144 * SCALE);
    localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);

    logic [CW-1:0] hc_q, vc_q;
    logic [SW-1:0] xs_q, ys_q;
    logic [7:0]    x_q;
    logic [14:0]   row_base_q, fb_a_q;
    logic          hs1_q, vs1_q, de1_q, win1_q;
    logic          hs2_q, vs2_q, de2_q, win2_q;
    logic          hsync_q, vsync_q, de_q;
    logic [11:0]   rgb_q;

    logic h_last, v_last, in_win_x, in_win_y, in_win, hs_raw, vs_raw, de_raw;

    assign h_last   = (hc_q == H_LAST);
    assign v_last   = (vc_q == V_LAST);
    assign in_win_x = (hc_q >= WX_BEG) && (hc_q < WX_END);
    assign in_win_y = (vc_q >= WY_BEG) && (vc_q < WY_END);
    assign in_win   = in_win_x && in_win_y;
    assign hs_raw   = !((hc_q >= HS_BEG) && (hc_q < HS_END));
    assign vs_raw   = !((vc_q >= VS_BEG) && (vc_q < VS_END));
    assign de_raw   = (hc_q < H_ACT) && (vc_q < V_ACT);

    function automatic logic [11:0] shade_rgb(input logic [1:0] s);
        case (s)
            2'd0:    return 12'hFFF;
            2'd1:    return 12'hAAA;
            2'd2:    return 12'h555;
            default: return 12'h000;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hc_q <= '0;
            vc_q <= '0;
        end else if (h_last) begin
            hc_q <= '0;
            vc_q <= v_last ? '0 : vc_q + 1'b1;
        end else begin
            hc_q <= hc_q + 1'b1;
        end
    end

    // Column/row sub-counters stand in for y*160+x without a multiplier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q        <= '0;
            xs_q       <= '0;
            ys_q       <= '0;
            row_base_q <= '0;
            fb_a_q     <= '0;
        end else begin
            if (in_win) begin
                fb_a_q <= row_base_q + {7'd0, x_q};
                if (xs_q == SUB_LAST) begin
                    xs_q <= '0;
                    x_q  <= x_q + 1'b1;
                end else begin
                    xs_q <= xs_q + 1'b1;
                end
            end else begin
                xs_q <= '0;
                x_q  <= '0;
            end
            if (h_last) begin
                if (v_last) begin
                    row_base_q <= '0;
                    ys_q       <= '0;
                end else if (in_win_y) begin
                    if (ys_q == SUB_LAST) begin
                        ys_q       <= '0;
                        row_base_q <= row_base_q + 15'd160;
                    end else begin
                        ys_q <= ys_q + 1'b1;
                    end
                end
            end
        end
    end

    // Timing flags ride alongside the RAM read so everything leaves aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs1_q   <= 1'b1;
            vs1_q   <= 1'b1;
            de1_q   <= 1'b0;
            win1_q  <= 1'b0;
            hs2_q   <= 1'b1;
            vs2_q   <= 1'b1;
            de2_q   <= 1'b0;
            win2_q  <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            de_q    <= 1'b0;
            rgb_q   <= '0;
        end else begin
            hs1_q   <= hs_raw;
            vs1_q   <= vs_raw;
            de1_q   <= de_raw;
            win1_q  <= in_win;
            hs2_q   <= hs1_q;
            vs2_q   <= vs1_q;
            de2_q   <= de1_q;
            win2_q  <= win1_q;
            hsync_q <= hs2_q;
            vsync_q <= vs2_q;
            de_q    <= de2_q;
            if (!de2_q)
                rgb_q <= 12'h000;
            else if (win2_q)
                rgb_q <= shade_rgb(bus.fb_dout);
            else
                rgb_q <= 12'h222;
        end
    end

`ifdef LCD_SCANOUT_DBUF_EN
    logic bank_q, pend_q, vs_start;

    assign vs_start = (hc_q == '0) && (vc_q == VS_BEG);

    // A pulse coinciding with the swap clock is kept for the following frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q <= 1'b0;
            pend_q <= 1'b0;
        end else if (vs_start && pend_q) begin
            bank_q <= ~bank_q;
            pend_q <= bus.frame_done;
        end else if (bus.frame_done) begin
            pend_q <= 1'b1;
        end
    end

    assign bus.fb_bank = bank_q;
`else
    logic unused_frame_done;
    assign unused_frame_done = bus.frame_done;
    assign bus.fb_bank       = 1'b0;
`endif

    assign bus.fb_a  = fb_a_q;
    assign bus.hsync = hsync_q;
    assign bus.vsync = vsync_q;
    assign bus.de    = de_q;
    assign bus.rgb   = rgb_q;
endmodule

// File: tb/tb_lcd_scanout.sv
// Directed bench for lcd_scanout: default raster for line-level checks, a reduced raster for
// whole-frame checks, and a tiny raster for mid-frame reset and bank swapping.
module tb_lcd_scanout;
    logic clk = 1'b0;
    logic rst_big, rst_sml, rst_tny;
    int   checks = 0;
    int   errors = 0;

    logic [1:0] a_big_prev, a_sml_prev, a_tny_prev;
    int p, hc, vc, q, ps, fs, hs, vs, qs, g, et;
    int bh, bd, sh, sv, sd, maxa;

    always #5 clk = ~clk;

    lcd_scanout_if if_big ();
    lcd_scanout_if if_sml ();
    lcd_scanout_if if_tny ();

    lcd_scanout u_big (.clk(clk), .rst(rst_big), .bus(if_big.master));

    lcd_scanout #(
        .H_ACTIVE(170), .H_FP(2), .H_SYNC(6), .H_BP(2),
        .V_ACTIVE(146), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SCALE(1), .X_OFF(5), .Y_OFF(1)
    ) u_sml (.clk(clk), .rst(rst_sml), .bus(if_sml.master));

    lcd_scanout #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .SCALE(2), .X_OFF(4), .Y_OFF(2)
    ) u_tny (.clk(clk), .rst(rst_tny), .bus(if_tny.master));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; the RAM model returns fb_a[1:0] one clock after the address is presented.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if_big.fb_dout = a_big_prev;
        if_sml.fb_dout = a_sml_prev;
        if_tny.fb_dout = a_tny_prev;
        a_big_prev = if_big.fb_a[1:0];
        a_sml_prev = if_sml.fb_a[1:0];
        a_tny_prev = if_tny.fb_a[1:0];
    endtask

    function automatic logic [11:0] exp_line24(input int c);
        int x;
        if (c < 80 || c >= 560) return 12'h222;
        x = (c - 80) / 3;
        case (x % 4)
            0:       return 12'hFFF;
            1:       return 12'hAAA;
            2:       return 12'h555;
            default: return 12'h000;
        endcase
    endfunction

    initial begin
        rst_big = 1'b1; rst_sml = 1'b1; rst_tny = 1'b1;
        if_big.fb_dout = 2'd0; if_sml.fb_dout = 2'd0; if_tny.fb_dout = 2'd0;
        if_big.frame_done = 1'b0; if_sml.frame_done = 1'b0; if_tny.frame_done = 1'b0;
        a_big_prev = 2'd0; a_sml_prev = 2'd0; a_tny_prev = 2'd0;
        bh = 0; bd = 0; sh = 0; sv = 0; sd = 0; maxa = 0;
        repeat (3) @(negedge clk);
        check("reset_big", {if_big.hsync, if_big.vsync, if_big.de, if_big.rgb, if_big.fb_a, if_big.fb_bank},
              {1'b1, 1'b1, 1'b0, 12'h000, 15'd0, 1'b0});
        check("reset_sml", {if_sml.hsync, if_sml.vsync, if_sml.de, if_sml.rgb, if_sml.fb_a, if_sml.fb_bank},
              {1'b1, 1'b1, 1'b0, 12'h000, 15'd0, 1'b0});
        rst_big = 1'b0; rst_sml = 1'b0; rst_tny = 1'b0;

        for (int e = 1; e <= 54003; e++) begin
            tick();
            if (e == 2) check("de_before_latency", if_big.de, 1'b0);
            if (e == 3) begin
                check("de_first_rise", if_big.de, 1'b1);
                check("rgb_first_border", if_big.rgb, 12'h222);
            end
            if (e >= 3 && e < 3 + 28 * 800) begin
                p = e - 3; hc = p % 800; vc = p / 800;
                if (!if_big.hsync) bh++;
                if (if_big.de) bd++;
                if (vc == 0 && hc == 655) check("hsync_pre_edge", if_big.hsync, 1'b1);
                if (vc == 0 && hc == 656) check("hsync_low_edge", if_big.hsync, 1'b0);
                if (vc == 24 && hc < 640) check("rgb_line24", if_big.rgb, exp_line24(hc));
                if (vc == 24 && hc == 700) check("rgb_blanking", if_big.rgb, 12'h000);
                if (hc == 799) begin
                    check("hsync_low_per_line", bh, 96);
                    check("de_per_line", bd, 640);
                    bh = 0; bd = 0;
                end
            end
            q = e - 1;
            if (q / 800 == 27 && q % 800 >= 80 && q % 800 < 560)
                check("fb_a_second_row", if_big.fb_a, 160 + (q % 800 - 80) / 3);
            if (q / 800 == 27 && q % 800 == 600)
                check("fb_a_hold", if_big.fb_a, 319);

            if (e >= 3) begin
                ps = e - 3; fs = ps / 27000; hs = ps % 180; vs = (ps / 180) % 150;
                if (fs < 2) begin
                    if (!if_sml.hsync) sh++;
                    if (!if_sml.vsync) sv++;
                    if (if_sml.de) sd++;
                    if (hs == 179) begin
                        check("sml_hsync_per_line", sh, 6);
                        sh = 0;
                    end
                    if (hs == 179 && vs == 146) check("sml_vsync_pre", if_sml.vsync, 1'b1);
                    if (hs == 0 && vs == 147) check("sml_vsync_start", if_sml.vsync, 1'b0);
                    if (hs == 179 && vs == 149) begin
                        check("sml_vsync_per_frame", sv, 360);
                        check("sml_de_per_frame", sd, 170 * 146);
                        sv = 0; sd = 0;
                    end
                end
            end
            qs = e - 1;
            if (qs < 54000) begin
                if (int'(if_sml.fb_a) > maxa) maxa = int'(if_sml.fb_a);
                if ((qs / 180) % 150 == 144 && qs % 180 >= 5 && qs % 180 < 165)
                    check("sml_last_row_addr", if_sml.fb_a, 22880 + qs % 180 - 5);
            end
        end
        check("fb_a_max", maxa, 23039);

        // Bring the tiny raster to hc=10, vc=5 and pulse reset there.
        g = 54003;
        for (int k = 0; k < 400 && (g % 384) != 130; k++) begin
            tick();
            g++;
        end
        check("tny_de_before_reset", if_tny.de, 1'b1);
        rst_tny = 1'b1;
        #1;
        check("tny_reset_async", {if_tny.hsync, if_tny.vsync, if_tny.de, if_tny.rgb, if_tny.fb_a, if_tny.fb_bank},
              {1'b1, 1'b1, 1'b0, 12'h000, 15'd0, 1'b0});
        tick();
        rst_tny = 1'b0;

        for (et = 1; et <= 1450; et++) begin
            tick();
            if_tny.frame_done = (et == 120 || et == 1056);
            if (et == 2)   check("tny_de_pre", if_tny.de, 1'b0);
            if (et == 3)   check("tny_de_rise", if_tny.de, 1'b1);
            if (et == 20)  check("tny_hsync_pre", if_tny.hsync, 1'b1);
            if (et == 21)  check("tny_hsync_low", if_tny.hsync, 1'b0);
            if (et == 290) check("tny_vsync_pre", if_tny.vsync, 1'b1);
            if (et == 291) check("tny_vsync_low", if_tny.vsync, 1'b0);
`ifdef LCD_SCANOUT_DBUF_EN
            if (et == 288)  check("bank_before_swap", if_tny.fb_bank, 1'b0);
            if (et == 289)  check("bank_swapped", if_tny.fb_bank, 1'b1);
            if (et == 673)  check("bank_no_pulse", if_tny.fb_bank, 1'b1);
            if (et == 1057) check("bank_deferred", if_tny.fb_bank, 1'b1);
            if (et == 1440) check("bank_pre_late_swap", if_tny.fb_bank, 1'b1);
            if (et == 1441) check("bank_late_swap", if_tny.fb_bank, 1'b0);
`else
            if (et == 289)  check("bank_fixed_a", if_tny.fb_bank, 1'b0);
            if (et == 1441) check("bank_fixed_b", if_tny.fb_bank, 1'b0);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lcd_scanout.md
Name: lcd_scanout

Overview:
- Display-side reader of the screen buffer that the PPU fills through its lcd_a / lcd_wr / pixel_out write port.
- Generates VGA-style raster timing and reads the 160x144 2-bit framebuffer over a synchronous read port.
- Scales each LCD pixel by an integer factor, centres the image in the active area and maps shades to 12-bit RGB.
- Sits between the framebuffer RAM's read port and the board video DAC / HDMI encoder.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- SCALE, 3, display pixels per LCD pixel, both axes (>=1)
- X_OFF, 80, first active column of the image
- Y_OFF, 24, first active line of the image

Ports:
- clk  input  1  pixel clock
- rst  input  1  asynchronous, active-high reset
- fb_a  output  15  framebuffer read address, y*160+x, range 0..23039
- fb_dout  input  2  framebuffer data, valid exactly 1 clock after fb_a
- frame_done  input  1  one-clock pulse from the PPU at end of a completed frame (vblank)
- fb_bank  output  1  framebuffer bank being scanned
- hsync  output  1  horizontal sync, active low
- vsync  output  1  vertical sync, active low
- de  output  1  data enable, high in the active area
- rgb  output  12  {R4,G4,B4} pixel colour

Behaviour:
- Reset (async) clears hc, vc, sub-counters, fb_a and the pipeline. Reset values: hsync=1, vsync=1, de=0, rgb=0, fb_a=0, fb_bank=0. Reset mid-frame restarts the raster at hc=0, vc=0; the first output follows 3 clocks after release.
- Counters:
  - hc counts 0..H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800) and wraps to 0.
  - vc increments when hc wraps; vc counts 0..V_TOTAL-1 (525) and wraps.
- Raw timing:
  - hsync is low for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync is low for vc in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
  - de = (hc<H_ACTIVE)&&(vc<V_ACTIVE).
- Image window: hc in [X_OFF, X_OFF+160*SCALE) and vc in [Y_OFF, Y_OFF+144*SCALE). Active pixels outside the window are border.
- Addressing uses no multiplier:
  - Horizontal: an x sub-counter repeats each LCD column SCALE times.
  - Vertical: a row_base register advances by 160 once every SCALE window lines.
  - fb_a = row_base + x. fb_a holds its last value outside the window.
- Pipeline:
  - S0 counters.
  - S1 fb_a registered (read issued).
  - S2 fb_dout valid.
  - S3 outputs registered.
  - hsync/vsync/de/in_window are delayed through matching stages, so every output lags its counter position by exactly 3 clocks.
- Palette at S3:
  - in window: shade 0->12'hFFF, 1->12'hAAA, 2->12'h555, 3->12'h000.
  - border: 12'h222.
  - de=0: rgb=12'h000.
- Window edges: the last column (x=159) and last row (y=143) display SCALE pixels wide / SCALE lines tall. row_base resets to 0 at vc=0.
- fb_dout is sampled only for in-window pixels.

Optional Feature:
- Macro: LCD_SCANOUT_DBUF_EN.
- Enabled:
  - A frame_done pulse sets a pending flag.
  - At the first clock of vsync assertion (S0 timing), a set flag toggles fb_bank and clears the flag.
  - A frame_done arriving on that same clock remains pending for the next frame.
  - fb_bank never changes mid-scan.
- Disabled: fb_bank is constant 0 and frame_done is ignored.

Test Plan:
- Reset release, free-run 2 frames -> hsync low 96 clocks per 800-clock line; vsync low 2 lines per 525-line frame; de high 640x480 per frame.
- Framebuffer model returning fb_a[1:0] -> at line Y_OFF, rgb is 12'h222 for active columns 0..79, then FFF x3, AAA x3, 555 x3, 000 x3 repeating, then 12'h222 from column 560.
- Address check -> at vc=Y_OFF+3, fb_a steps 160..319. The last window line (vc=455) uses addresses 22880..23039. fb_a never exceeds 23039.
- Latency -> rgb/de/hsync of counter position (hc,vc) appear exactly 3 clocks later; the first de rise occurs 3 clocks after hc=0, vc=0.
- Assert rst for 1 clock at hc=300, vc=200 -> outputs take reset values immediately; the next frame starts cleanly with vsync timing from vc=0.
- LCD_SCANOUT_DBUF_EN: frame_done pulse at vc=100 -> fb_bank toggles at the vsync start of that frame only. A frame with no pulse -> no toggle. A pulse on the vsync-start clock -> toggle deferred one frame.
